music_score_recorder: RTL
=========================

# music_score_recorder

Records a live melody played on the three note keys into the MusicScore RAM as (key, duration) entries, ready for the score-playback path to read back. It sits between the debounced key inputs and the write side of MusicScore, sharing the same address/key/time data format the playback path reads. It terminates every recording with an end-of-score entry.

## Interface
- AddressBits, 5, score RAM address width.
- DataLength, 4, key and duration field width.
- TickCycles, 12_500_000, Clock cycles per duration unit (0.25 s at 50 MHz).
- Clock  input  1  system clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Record  input  1  single-cycle start pulse (already debounced and one-shot).
- Stop  input  1  single-cycle stop pulse (already debounced and one-shot).
- Keys  input  3  debounced levels: [0]=C, [1]=D, [2]=E.
- ReadOrWrite  output  1  to MusicScore: 1=read, 0=write this cycle.
- Address  output  AddressBits  score RAM address.
- KeyInput  output  DataLength  key code written.
- TimeInput  output  DataLength  duration written, in ticks.
- Recording  output  1  high from Record acceptance until the end marker is written.
- Full  output  1  high once a recording ended by filling the RAM; cleared by next Record.

## Operation
- Key codes: 0=rest, 1=C, 2=D, 3=E. Priority C>D>E when several keys are held.
- End-of-score entry: key 0, time 0. A rest is key 0 with time ≥1.
- States: IDLE, ARMED, TIMING, WRITE, TERMINATE.
- IDLE: Record → ARMED; Address←0, Full←0, Recording←1. Stop ignored.
- ARMED: leading rest discarded. Nonzero key → TIMING; CurrentKey←code, Duration←1, prescaler←0. Stop → TERMINATE.
- TIMING: prescaler counts to TickCycles-1 then wraps. Each wrap increments Duration.
  - Encoded key ≠ CurrentKey → WRITE of (CurrentKey, Duration). CurrentKey←new code, Duration←1, prescaler←0.
  - Wrap with Duration=2^DataLength-1 → WRITE of (CurrentKey, 15). The same key continues with Duration←1.
  - Stop → TERMINATE if CurrentKey is rest (trailing rest dropped). Otherwise → WRITE of the pending entry, then TERMINATE.
- WRITE: ReadOrWrite=0 for exactly one cycle, then Address increments.
  - If the incremented Address equals 2^AddressBits-1 (the last slot, reserved for the end marker): Full←1, → TERMINATE.
  - Otherwise → TERMINATE if a Stop is pending, else TIMING.
- TERMINATE: writes (0,0) at Address for one cycle, Recording←0, → IDLE.
- Record while not IDLE: ignored. Stop arriving during WRITE: latched as pending and honored when WRITE exits.
- Arithmetic: Duration saturates at 15 by splitting into entries; it never wraps to 0. Address never exceeds 2^AddressBits-1.

## Timing
- Reset values: ReadOrWrite=1, Address=0, KeyInput=0, TimeInput=0, Recording=0, Full=0, state IDLE.
- Outside WRITE/TERMINATE cycles: ReadOrWrite=1 and KeyInput/TimeInput hold 0.
- Key change sampled at edge n → write cycle (ReadOrWrite=0) during cycle n+1 → Address increments at edge n+2.
- Record at edge n → Recording high from cycle n+1.
- Stop with nonzero CurrentKey: entry write cycle, then end-marker write cycle, then Recording low.
- Each write cycle presents Address, KeyInput and TimeInput stable for the whole cycle with ReadOrWrite=0.
- The prescaler keeps running through a same-key split WRITE cycle, so tick spacing is preserved.
- Reset asserted mid-recording aborts immediately, with no end marker written. Outputs go to their reset values asynchronously.

## Structure
- Shared include holds the key codes (REST, KEY_C, KEY_D, KEY_E), the end-marker value and the state encodings; the playback side uses the same include.
- One sub-module: TickGenerator (parameter TickCycles; inputs Clear, Clock, Reset; output Tick as a one-cycle pulse).

## Test plan
All scenarios use TickCycles=4.
1. Record; Keys=001 for 12 cycles; Keys=000; Stop → writes (1,3) at addr 0, then (0,0) at addr 1. Recording drops after the marker; Full=0.
2. Record; idle 20 cycles; Keys=010 for 8 cycles; Keys=100 for 4 cycles; Stop → entries (2,2),(3,1),(0,0) at addrs 0–2. The leading rest is absent.
3. Record; hold C for 80 cycles; Stop → (1,15) at addr 0, (1,5) at addr 1, (0,0) at addr 2.
4. Record; toggle C / D every 4 cycles beyond 31 notes → 31 entries at addrs 0–30, (0,0) at addr 31, Full=1, then IDLE.
5. Record; assert Reset mid-TIMING → outputs return to reset values at once with no marker write. A second Record then restarts at addr 0.
6. Stop in IDLE → no write. Record during TIMING → ignored. Stop issued during a WRITE cycle → marker written right after the entry.

Source files
------------

// File: rtl/music_score_recorder_pkg.sv
// Shared score format: key codes, end-of-score marker and recorder state encodings.
// Also used by the playback side so both paths agree on entry layout.
package music_score_recorder_pkg;

    localparam logic [1:0] REST  = 2'd0;
    localparam logic [1:0] KEY_C = 2'd1;
    localparam logic [1:0] KEY_D = 2'd2;
    localparam logic [1:0] KEY_E = 2'd3;

    localparam logic [1:0] END_KEY  = REST;
    localparam int         END_TIME = 0;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TIMING,
        WRITE,
        TERMINATE
    } recorderState_t;

    // C wins over D, D over E when several keys are held together.
    function automatic logic [1:0] encodeKeys(input logic [2:0] keys);
        logic [1:0] code;
        code = REST;
        if (keys[0])      code = KEY_C;
        else if (keys[1]) code = KEY_D;
        else if (keys[2]) code = KEY_E;
        return code;
    endfunction

endpackage

// File: rtl/TickGenerator.sv
// Duration prescaler: Tick is high for one cycle every TickCycles cycles; Clear restarts the count.
// Tick is combinational from the counter, no input backpressure.
module TickGenerator #(
    parameter int TickCycles = 12_500_000
) (
    input  logic Clear,
    input  logic Clock,
    input  logic Reset,
    output logic Tick
);

    localparam int CountBits = (TickCycles > 1) ? $clog2(TickCycles) : 1;
    localparam logic [CountBits-1:0] LastCount = CountBits'(TickCycles - 1);

    logic [CountBits-1:0] count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (Clear || count == LastCount) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign Tick = (count == LastCount);

endmodule

// File: rtl/music_score_recorder.sv
// Records key presses as (key, duration) entries into the score RAM write port, ending with (0,0).
// One write cycle per entry, issued the cycle after the key change is sampled; the RAM never stalls it.
module music_score_recorder
    import music_score_recorder_pkg::*;
#(
    parameter int AddressBits = 5,
    parameter int DataLength  = 4,
    parameter int TickCycles  = 12_500_000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Record,
    input  logic                   Stop,
    input  logic [2:0]             Keys,
    output logic                   ReadOrWrite,
    output logic [AddressBits-1:0] Address,
    output logic [DataLength-1:0]  KeyInput,
    output logic [DataLength-1:0]  TimeInput,
    output logic                   Recording,
    output logic                   Full
);

    localparam logic [DataLength-1:0]  MaxDuration = '1;
    localparam logic [DataLength-1:0]  OneDuration = DataLength'(1);
    localparam logic [DataLength-1:0]  RestCode    = DataLength'(REST);
    localparam logic [AddressBits-1:0] LastSlot    = '1;

    recorderState_t state, stateNext;

    logic [DataLength-1:0]  currentKey, currentKeyNext;
    logic [DataLength-1:0]  duration, durationNext;
    logic [DataLength-1:0]  writeKey, writeKeyNext;
    logic [DataLength-1:0]  writeTime, writeTimeNext;
    logic [AddressBits-1:0] address, addressNext;
    logic [AddressBits-1:0] addressInc;
    logic                   full, fullNext;
    logic                   stopPending, stopPendingNext;
    logic                   prescalerClear;
    logic                   tick;
    logic [DataLength-1:0]  keyCode;

    assign keyCode    = DataLength'(encodeKeys(Keys));
    assign addressInc = address + 1'b1;

    TickGenerator #(
        .TickCycles(TickCycles)
    ) tickGenerator (
        .Clear (prescalerClear),
        .Clock (Clock),
        .Reset (Reset),
        .Tick  (tick)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            currentKey  <= '0;
            duration    <= '0;
            writeKey    <= '0;
            writeTime   <= '0;
            address     <= '0;
            full        <= 1'b0;
            stopPending <= 1'b0;
        end else begin
            state       <= stateNext;
            currentKey  <= currentKeyNext;
            duration    <= durationNext;
            writeKey    <= writeKeyNext;
            writeTime   <= writeTimeNext;
            address     <= addressNext;
            full        <= fullNext;
            stopPending <= stopPendingNext;
        end
    end

    always_comb begin
        stateNext       = state;
        currentKeyNext  = currentKey;
        durationNext    = duration;
        writeKeyNext    = writeKey;
        writeTimeNext   = writeTime;
        addressNext     = address;
        fullNext        = full;
        stopPendingNext = stopPending;
        prescalerClear  = 1'b0;
        ReadOrWrite     = 1'b1;
        KeyInput        = '0;
        TimeInput       = '0;

        case (state)
            IDLE: begin
                prescalerClear = 1'b1;
                if (Record) begin
                    stateNext       = ARMED;
                    addressNext     = '0;
                    fullNext        = 1'b0;
                    stopPendingNext = 1'b0;
                end
            end

            ARMED: begin
                prescalerClear = 1'b1;
                if (Stop) begin
                    stateNext = TERMINATE;
                end else if (keyCode != RestCode) begin
                    stateNext      = TIMING;
                    currentKeyNext = keyCode;
                    durationNext   = OneDuration;
                end
            end

            TIMING: begin
                // Stop outranks a simultaneous key change or tick; the pending entry keeps its count.
                if (Stop) begin
                    if (currentKey == RestCode) begin
                        stateNext = TERMINATE;
                    end else begin
                        stateNext       = WRITE;
                        writeKeyNext    = currentKey;
                        writeTimeNext   = duration;
                        stopPendingNext = 1'b1;
                    end
                end else if (keyCode != currentKey) begin
                    stateNext      = WRITE;
                    writeKeyNext   = currentKey;
                    writeTimeNext  = duration;
                    currentKeyNext = keyCode;
                    durationNext   = OneDuration;
                    prescalerClear = 1'b1;
                end else if (tick) begin
                    if (duration == MaxDuration) begin
                        stateNext     = WRITE;
                        writeKeyNext  = currentKey;
                        writeTimeNext = MaxDuration;
                        durationNext  = OneDuration;
                    end else begin
                        durationNext = duration + 1'b1;
                    end
                end
            end

            WRITE: begin
                ReadOrWrite = 1'b0;
                KeyInput    = writeKey;
                TimeInput   = writeTime;
                addressNext = addressInc;
                if (tick && duration != MaxDuration) begin
                    durationNext = duration + 1'b1;
                end
                // The last slot is kept for the end marker.
                if (addressInc == LastSlot) begin
                    fullNext  = 1'b1;
                    stateNext = TERMINATE;
                end else if (stopPending || Stop) begin
                    stateNext = TERMINATE;
                end else begin
                    stateNext = TIMING;
                end
            end

            TERMINATE: begin
                ReadOrWrite     = 1'b0;
                KeyInput        = DataLength'(END_KEY);
                TimeInput       = DataLength'(END_TIME);
                stopPendingNext = 1'b0;
                stateNext       = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign Address   = address;
    assign Recording = (state != IDLE);
    assign Full      = full;

endmodule
